apb_protocol_checker: RTL

- Synthesizable, parametrised APB3 protocol checker.
- Passively observes one APB requester/completer pair and tracks the IDLE/SETUP/ACCESS phase sequence.
- Flags protocol violations with coded errors, times out stalled transfers, and keeps saturating transfer statistics.
- Sits beside the APB interface in both the bench and the DUT wrapper; replaces the single fixed-width pready assertion with a configurable, register-visible checker.

---
 rtl/apb_chk_pkg.sv | 34 +++
 rtl/apb_sat_counter.sv | 31 +++
 rtl/apb_protocol_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/apb_chk_pkg.sv
// Shared types for the APB3 protocol checker: bus phases, violation codes and
// the priority encoder that picks the reported code.
package apb_chk_pkg;

    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_e;

    typedef enum logic [3:0] {
        ERR_NONE            = 4'd0,
        ERR_ENABLE_NO_SETUP = 4'd1,
        ERR_SETUP_ABORT     = 4'd2,
        ERR_NO_ENABLE       = 4'd3,
        ERR_UNSTABLE        = 4'd4,
        ERR_TIMEOUT         = 4'd5,
        ERR_PENABLE_HELD    = 4'd6,
        ERR_DROP_IN_ACCESS  = 4'd7
    } err_code_e;

    // Lowest set violation bit wins when several fire on one edge.
    function automatic err_code_e lowest_code(input logic [7:0] viol);
        err_code_e code;
        code = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (viol[i]) code = err_code_e'(4'(i));
        end
        return code;
    endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-edge increment.
module apb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3 checker: follows IDLE/SETUP/ACCESS, reports coded violations,
// times out long stalls and keeps saturating transfer statistics.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 5,
    parameter int CNT_W    = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr_stats,
    output logic [1:0]        phase,
    output logic              err_valid,
    output logic [3:0]        err_code,
    output logic [7:0]        err_sticky,
    output logic [7:0]        wait_cnt,
    output logic [7:0]        max_wait_seen,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  slverr_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    phase_e              phase_q, phase_d;
    logic                done_q, done_d;
    logic                to_fired_q, to_fired_d;
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    logic                cap_write_q, cap_write_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]   max_wait_q, max_wait_d;
    logic                err_valid_q, err_valid_d;
    err_code_e           err_code_q, err_code_d;
    logic [7:0]          err_sticky_q, err_sticky_d;
    logic [7:0]          viol;
    logic                wr_inc, rd_inc, se_inc;
    logic                prdata_unused;

    // Read data is observed only so the whole bus can be bound to the checker.
    assign prdata_unused = ^prdata;

    always_comb begin
        phase_d     = phase_q;
        done_d      = 1'b0;
        to_fired_d  = to_fired_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_write_d = cap_write_q;
        wait_cnt_d  = wait_cnt_q;
        max_wait_d  = clr_stats ? '0 : max_wait_q;
        viol        = '0;
        wr_inc      = 1'b0;
        rd_inc      = 1'b0;
        se_inc      = 1'b0;

        unique case (phase_q)
            PH_IDLE: begin
                if (psel && !penable) begin
                    phase_d     = PH_SETUP;
                    cap_addr_d  = paddr;
                    cap_write_d = pwrite;
                    cap_wdata_d = pwdata;
                end else if (psel && penable) begin
                    // done_q marks the sample right after a completion
                    if (done_q) viol[6] = 1'b1;
                    else        viol[1] = 1'b1;
                end
            end
            PH_SETUP: begin
                if (psel && penable) begin
                    phase_d    = PH_ACCESS;
                    wait_cnt_d = '0;
                    to_fired_d = 1'b0;
                end else if (!psel) begin
                    viol[2] = 1'b1;
                    phase_d = PH_IDLE;
                end else begin
                    viol[3] = 1'b1;
                    phase_d = PH_IDLE;
                end
            end
            PH_ACCESS: begin
                if ((paddr != cap_addr_q) || (pwrite != cap_write_q) ||
                    (cap_write_q && (pwdata != cap_wdata_q))) begin
                    viol[4] = 1'b1;
                end
                if (!psel || !penable) begin
                    viol[7] = 1'b1;
                    phase_d = PH_IDLE;
                end else if (pready) begin
                    phase_d = PH_IDLE;
                    done_d  = 1'b1;
                    wr_inc  = cap_write_q;
                    rd_inc  = !cap_write_q;
                    se_inc  = pslverr;
                    if (!clr_stats && (wait_cnt_q > max_wait_q)) max_wait_d = wait_cnt_q;
                end else begin
                    if ((wait_cnt_q == MAX_WAIT_C) && !to_fired_q) begin
                        viol[5]    = 1'b1;
                        to_fired_d = 1'b1;
                    end
                    if (wait_cnt_q != {WAIT_W{1'b1}}) wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        err_valid_d  = |viol;
        err_code_d   = lowest_code(viol);
        err_sticky_d = ((clr_stats ? 8'h00 : err_sticky_q) | viol) & 8'hFE;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q      <= PH_IDLE;
            done_q       <= 1'b0;
            to_fired_q   <= 1'b0;
            cap_addr_q   <= '0;
            cap_wdata_q  <= '0;
            cap_write_q  <= 1'b0;
            wait_cnt_q   <= '0;
            max_wait_q   <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= '0;
        end else begin
            phase_q      <= phase_d;
            done_q       <= done_d;
            to_fired_q   <= to_fired_d;
            cap_addr_q   <= cap_addr_d;
            cap_wdata_q  <= cap_wdata_d;
            cap_write_q  <= cap_write_d;
            wait_cnt_q   <= wait_cnt_d;
            max_wait_q   <= max_wait_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    apb_sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk (pclk), .rst (rst), .inc (wr_inc), .clr (clr_stats), .cnt (wr_cnt)
    );

    apb_sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk (pclk), .rst (rst), .inc (rd_inc), .clr (clr_stats), .cnt (rd_cnt)
    );

    apb_sat_counter #(.W(CNT_W)) u_slverr_cnt (
        .clk (pclk), .rst (rst), .inc (se_inc), .clr (clr_stats), .cnt (slverr_cnt)
    );

    assign phase         = phase_q;
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;
    assign err_sticky    = err_sticky_q;
    assign wait_cnt      = wait_cnt_q;
    assign max_wait_seen = max_wait_q;

endmodule
